// File: rtl/tt_bin_clock_set_ctrl.sv
// Set-mode controller for the binary clock core.
// Three raw buttons are synchronised and debounced, then steer a small
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC FSM that issues one-cycle adjust
// pulses with auto-repeat, an idle timeout and a blink enable.
module tt_bin_clock_set_ctrl #(
  parameter int unsigned DB_CYCLES    = 3,
  parameter int unsigned REPEAT_DELAY = 100,
  parameter int unsigned REPEAT_RATE  = 25,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned BLINK_HALF   = 50
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic       time_set,
  output logic       id_switch,
  output logic       hour_id,
  output logic       minute_id,
  output logic       seconds_id,
  output logic [1:0] field_sel,
  output logic       blink
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_t;

  localparam int unsigned B_MODE  = 0;
  localparam int unsigned B_UP    = 1;
  localparam int unsigned B_DN    = 2;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_HALF + 1);

  logic [2:0]        raw;
  logic [2:0]        sync1_q;
  logic [2:0]        sync2_q;
  logic [2:0]        db_q;
  logic [2:0]        db_d1_q;
  logic [2:0]        rise_q;
  logic [DB_W-1:0]   db_cnt_q [3];

  state_t            state_q;
  state_t            state_d;
  logic              block_q;
  logic              block_d;
  logic              armed_q;
  logic              armed_d;
  logic [RPT_W-1:0]  rpt_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [BLK_W-1:0]  blink_cnt_q;

  logic              mode_ev;
  logic              up_ev;
  logic              dn_ev;
  logic              both_hi;
  logic              any_hi;
  logic              in_set;
  logic              held;
  logic              timeout;
  logic              fire;
  logic              fire_dir;
  logic              load_delay;
  logic              load_rate;

  assign raw     = {down_btn, up_btn, mode_btn};
  assign mode_ev = rise_q[B_MODE];
  assign up_ev   = rise_q[B_UP];
  assign dn_ev   = rise_q[B_DN];
  assign both_hi = db_q[B_UP] & db_q[B_DN];
  assign any_hi  = |db_q;
  assign in_set  = (state_q != S_RUN);
  // id_switch holds the direction of the pulse that armed the repeat.
  assign held    = id_switch ? db_q[B_UP] : db_q[B_DN];
  assign timeout = in_set && !any_hi && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: adopt a new level after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Registered rising-edge events of the debounced levels.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_d1_q <= '0;
      rise_q  <= '0;
    end else begin
      db_d1_q <= db_q;
      rise_q  <= db_q & ~db_d1_q;
    end
  end

  // FSM state, repeat arming and up/down lockout registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_RUN;
      block_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      armed_q <= armed_d;
    end
  end

  // Next state and pulse request; mode beats timeout beats up/down.
  always_comb begin
    state_d    = state_q;
    block_d    = block_q;
    armed_d    = armed_q;
    fire       = 1'b0;
    fire_dir   = id_switch;
    load_delay = 1'b0;
    load_rate  = 1'b0;
    if (!db_q[B_UP] && !db_q[B_DN]) block_d = 1'b0;
    if (!held) armed_d = 1'b0;
    if (mode_ev) begin
      case (state_q)
        S_RUN:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        default: state_d = S_RUN;
      endcase
      block_d = 1'b1;
      armed_d = 1'b0;
    end else if (timeout) begin
      state_d = S_RUN;
      armed_d = 1'b0;
    end else if (both_hi) begin
      block_d = 1'b1;
      armed_d = 1'b0;
    end else if (in_set && !block_q && (up_ev || dn_ev)) begin
      fire       = 1'b1;
      fire_dir   = up_ev;
      armed_d    = 1'b1;
      load_delay = 1'b1;
    end else if (in_set && armed_q && held && (rpt_cnt_q == '0)) begin
      fire      = 1'b1;
      load_rate = 1'b1;
    end
  end

  // Repeat, idle and blink counters; all reload or saturate.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rpt_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
    end else begin
      if (load_delay)               rpt_cnt_q <= RPT_W'(REPEAT_DELAY - 1);
      else if (load_rate)           rpt_cnt_q <= RPT_W'(REPEAT_RATE - 1);
      else if (!armed_d)            rpt_cnt_q <= '0;
      else if (rpt_cnt_q != '0)     rpt_cnt_q <= rpt_cnt_q - 1'b1;

      if (state_d == S_RUN || state_d != state_q || any_hi)
        idle_cnt_q <= '0;
      else if (idle_cnt_q != IDLE_W'(TIMEOUT - 1))
        idle_cnt_q <= idle_cnt_q + 1'b1;

      if (state_d == S_RUN || state_d != state_q || blink_cnt_q == BLK_W'(BLINK_HALF - 1))
        blink_cnt_q <= '0;
      else
        blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Registered outputs, computed from the next state and pulse request.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      time_set   <= 1'b0;
      id_switch  <= 1'b1;
      hour_id    <= 1'b0;
      minute_id  <= 1'b0;
      seconds_id <= 1'b0;
      field_sel  <= '0;
      blink      <= 1'b0;
    end else begin
      time_set   <= (state_d != S_RUN);
      field_sel  <= state_d;
      hour_id    <= fire && (state_q == S_HOUR);
      minute_id  <= fire && (state_q == S_MIN);
      seconds_id <= fire && (state_q == S_SEC);
      if (fire) id_switch <= fire_dir;
      if (state_d == S_RUN)
        blink <= 1'b0;
      else if (state_d != state_q)
        blink <= 1'b1;
      else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1))
        blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_tt_bin_clock_set_ctrl.sv
// Bench for tt_bin_clock_set_ctrl: directed scenarios plus random presses.
// Expected pulses and field changes are queued when a press is issued and
// popped by an independent monitor whenever the DUT shows one.
module tb_tt_bin_clock_set_ctrl;

  localparam int DB = 3;
  localparam int RD = 100;
  localparam int RR = 25;
  localparam int TO = 1000;
  localparam int BH = 50;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       mode_btn;
  logic       up_btn;
  logic       down_btn;
  logic       time_set;
  logic       id_switch;
  logic       hour_id;
  logic       minute_id;
  logic       seconds_id;
  logic [1:0] field_sel;
  logic       blink;

  tt_bin_clock_set_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .mode_btn(mode_btn), .up_btn(up_btn),
    .down_btn(down_btn), .time_set(time_set), .id_switch(id_switch),
    .hour_id(hour_id), .minute_id(minute_id), .seconds_id(seconds_id),
    .field_sel(field_sel), .blink(blink)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int field;
    int dir;
    int tol;
  } exp_t;

  exp_t pq[$];
  exp_t sq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   s        = 0;   // model of the active field: 0 RUN, 1 HOUR, 2 MIN, 3 SEC

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic void push_pulse(input int c, input int f, input int d);
    exp_t e;
    e.cyc = c; e.field = f; e.dir = d; e.tol = 0;
    pq.push_back(e);
  endfunction

  function automatic void push_state(input int c, input int f, input int tol);
    exp_t e;
    e.cyc = c; e.field = f; e.dir = 0; e.tol = tol;
    sq.push_back(e);
  endfunction

  // Reference: a raw press first sampled at edge c and held len edges.
  // Accepted if len >= DB; response lands DB+3 edges after c; the level is
  // seen high up to edge c+len+1+DB, which bounds the auto-repeat train.
  function automatic void model_press(input int b, input int c, input int len);
    int e;
    int lim;
    int d;
    if (len < DB) return;
    if (b == 0) begin
      s = (s + 1) % 4;
      push_state(c + DB + 3, s, 0);
    end else if (s != 0) begin
      d   = (b == 1) ? 1 : 0;
      e   = c + DB + 3;
      lim = c + len + 1 + DB;
      push_pulse(e, s, d);
      for (e = e + RD; e <= lim; e += RR) push_pulse(e, s, d);
    end
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       mode_btn = v;
      1:       up_btn   = v;
      default: down_btn = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic press(input int b, input int len, output int c);
    @(negedge clk_i);
    c = cyc + 1;
    model_press(b, c, len);
    set_btn(b, 1'b1);
    repeat (len) @(negedge clk_i);
    set_btn(b, 1'b0);
  endtask

  task automatic mode_step();
    int c;
    press(0, 10, c);
    idle(20);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_time_set"},  time_set == 1'b0, int'(time_set), 0);
    check({tag, "_id_switch"}, id_switch == 1'b1, int'(id_switch), 1);
    check({tag, "_ids"}, {hour_id, minute_id, seconds_id} == 3'b000,
          int'({hour_id, minute_id, seconds_id}), 0);
    check({tag, "_field_sel"}, field_sel == 2'd0, int'(field_sel), 0);
    check({tag, "_blink"},     blink == 1'b0, int'(blink), 0);
  endtask

  // Monitor: pops an expectation whenever a pulse or a field change appears.
  initial begin : monitor
    int   last_f;
    int   nid;
    int   f;
    exp_t e;
    last_f = 0;
    forever begin
      @(negedge clk_i);
      nid = int'(hour_id) + int'(minute_id) + int'(seconds_id);
      if (nid != 0) begin
        f = hour_id ? 1 : (minute_id ? 2 : 3);
        check("pulse_onehot", nid == 1, nid, 1);
        check("pulse_expected", pq.size() != 0, pq.size(), 1);
        if (pq.size() != 0) begin
          e = pq.pop_front();
          check("pulse_cycle", cyc == e.cyc, cyc, e.cyc);
          check("pulse_field", f == e.field, f, e.field);
          check("pulse_dir", int'(id_switch) == e.dir, int'(id_switch), e.dir);
        end
      end
      if (int'(field_sel) != last_f) begin
        last_f = int'(field_sel);
        check("state_expected", sq.size() != 0, sq.size(), 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          check("state_cycle", (cyc >= e.cyc - e.tol) && (cyc <= e.cyc + e.tol), cyc, e.cyc);
          check("state_field", last_f == e.field, last_f, e.field);
          check("state_time_set", int'(time_set) == ((e.field != 0) ? 1 : 0), int'(time_set),
                (e.field != 0) ? 1 : 0);
          check("state_blink", int'(blink) == ((e.field != 0) ? 1 : 0), int'(blink),
                (e.field != 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin : stim
    int c;
    int m;
    int b;
    int len;
    int entry;
    int t_out;
    reset_ni = 1'b0;
    mode_btn = 1'b0;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_checks("rst0");
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    idle(5);

    // Mode walk RUN -> HOUR -> MIN -> SEC -> RUN.
    repeat (4) mode_step();

    // SET_MIN: short glitch ignored, 6-cycle hold gives one minute pulse.
    repeat (2) mode_step();
    press(1, 2, c);
    idle(20);
    press(1, 6, c);
    idle(20);

    // SET_HOUR: long down hold gives first pulse plus auto-repeat train.
    repeat (3) mode_step();
    press(2, 200, c);
    idle(20);

    // SET_SEC: both held, then down released with up still held: no pulses.
    repeat (2) mode_step();
    @(negedge clk_i);
    up_btn   = 1'b1;
    down_btn = 1'b1;
    idle(30);
    down_btn = 1'b0;
    idle(30);
    up_btn = 1'b0;
    idle(20);
    press(1, 6, c);
    idle(20);

    // Idle timeout from SET_HOUR, with blink phase checks along the way.
    mode_step();
    press(0, 10, c);
    entry = c + DB + 3;
    t_out = c + 10 + 1 + DB + TO;
    push_state(t_out, 0, 2);
    s = 0;
    wait_cyc(entry + BH / 2);
    check("blink_first_half", blink == 1'b1, int'(blink), 1);
    wait_cyc(entry + BH + BH / 2);
    check("blink_second_half", blink == 1'b0, int'(blink), 0);
    wait_cyc(entry + 2 * BH + BH / 2);
    check("blink_third_half", blink == 1'b1, int'(blink), 1);
    wait_cyc(t_out + 20);

    // Random separated presses: glitches, short and long holds, any button.
    for (int i = 0; i < 25; i++) begin
      b   = int'($urandom_range(0, 2));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1))
                                        : int'($urandom_range(DB, DB + 250));
      press(b, len, c);
      idle(int'($urandom_range(10, 60)));
    end

    // Reset during auto-repeat; mode and down held through reset release.
    while (s != 1) mode_step();
    @(negedge clk_i);
    c = cyc + 1;
    down_btn = 1'b1;
    push_pulse(c + DB + 3, 1, 0);
    push_pulse(c + DB + 3 + RD, 1, 0);
    wait_cyc(c + DB + 3 + RD + 10);
    reset_ni = 1'b0;
    m = cyc;
    push_state(m, 0, 0);
    s = 0;
    #1 reset_checks("rst_async");
    mode_btn = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 reset_checks("rst_hold");
    reset_ni = 1'b1;
    m = cyc;
    push_state(m + 1 + DB + 3, 1, 0);
    s = 1;
    idle(12);
    mode_btn = 1'b0;
    idle(10);
    down_btn = 1'b0;
    idle(40);

    check("pulse_queue_drained", pq.size() == 0, pq.size(), 0);
    check("state_queue_drained", sq.size() == 0, sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_bin_clock_set_ctrl.md
TT_BIN_CLOCK_SET_CTRL -- requirements
Module: tt_bin_clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 3: consecutive stable samples needed to accept a button level change.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 100: cycles from the first adjust pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 25: cycles between successive auto-repeat pulses.
REQ-004 The block SHALL have parameter TIMEOUT, default 1000: idle cycles in a set state before returning to RUN.
REQ-005 The block SHALL have parameter BLINK_HALF, default 50: cycles per blink half-period.
REQ-006 Port clk_i  input  1  system clock, 100 Hz nominal; the only clock.
REQ-007 Port reset_ni  input  1  asynchronous, active-low reset.
REQ-008 Port mode_btn  input  1  raw asynchronous mode button, active-high.
REQ-009 Port up_btn  input  1  raw asynchronous increment button, active-high.
REQ-010 Port down_btn  input  1  raw asynchronous decrement button, active-high.
REQ-011 Port time_set  output  1  drives the clock core's set-mode input.
REQ-012 Port id_switch  output  1  drives the core's direction input; 1 = increment, 0 = decrement.
REQ-013 Port hour_id  output  1  one-cycle hour adjust pulse.
REQ-014 Port minute_id  output  1  one-cycle minute adjust pulse.
REQ-015 Port seconds_id  output  1  one-cycle seconds adjust pulse.
REQ-016 Port field_sel  output  2  active state: 0 RUN, 1 HOUR, 2 MIN, 3 SEC.
REQ-017 Port blink  output  1  display blink enable for the selected field.

Function
REQ-018 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DB_CYCLES consecutive identical synchronized samples.
REQ-019 A debounced rising edge SHALL be detected as a one-cycle internal event.
REQ-020 The FSM SHALL have states RUN, SET_HOUR, SET_MIN and SET_SEC; a mode event SHALL step RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-021 time_set SHALL be 1 in every SET state and 0 in RUN; field_sel SHALL encode the current state; all outputs SHALL be registered.
REQ-022 In a SET state, an up event SHALL produce exactly one cycle of the selected field's *_id with id_switch=1 in the same cycle; a down event SHALL do the same with id_switch=0.
REQ-023 id_switch SHALL hold its last value outside pulses; at most one *_id output SHALL be high in any cycle.
REQ-024 From a clean raw press held high, the first *_id pulse SHALL be asserted DB_CYCLES+3 clock edges after the first edge that samples the raw input high.
REQ-025 While the initiating debounced button stays high, auto-repeat pulses SHALL follow REPEAT_DELAY cycles after the first pulse, then every REPEAT_RATE cycles, with the same direction.
REQ-026 When debounced up and down are both high, no pulse SHALL be issued, the repeat counter SHALL clear, and repeat SHALL stay disarmed until both are released.
REQ-027 Up and down events in RUN SHALL be ignored and SHALL produce no pulse.
REQ-028 A mode event SHALL take priority over an up/down event in the same cycle: the state advances, no pulse is issued, and repeat is disarmed until up and down are released.
REQ-029 The idle counter SHALL clear on any debounced button high level; after TIMEOUT consecutive idle cycles in a SET state, the FSM SHALL return to RUN.
REQ-030 blink SHALL toggle every BLINK_HALF cycles in SET states, SHALL start at 1 on each SET entry, and SHALL be 0 in RUN.
REQ-031 Counters SHALL saturate or reload and SHALL never wrap into spurious pulses.

Reset
REQ-032 While reset_ni=0, the block SHALL hold state RUN, time_set=0, id_switch=1, hour_id/minute_id/seconds_id=0, field_sel=0 and blink=0, and SHALL clear synchronizers, debounced levels and all counters.
REQ-033 Reset asserted mid-press or mid-repeat SHALL abort immediately, with no pulse on the release of reset; a button held through reset deassertion SHALL be treated as a new press once debounced.

Verification
REQ-034 Bench: press mode 4 times (each held 10 cycles) -> field_sel 1,2,3,0; time_set 1,1,1,0.
REQ-035 Bench: in SET_MIN, a 2-cycle glitch on up_btn -> no pulse; hold up 6 cycles -> single minute_id pulse, id_switch=1, at edge DB_CYCLES+3.
REQ-036 Bench: in SET_HOUR, hold down for 200 cycles -> hour_id pulses at t0, t0+100, t0+125, t0+150, t0+175, all with id_switch=0.
REQ-037 Bench: in SET_SEC, up and down held together -> no pulses; release down while up is still held -> no pulse until up is released and pressed again.
REQ-038 Bench: enter SET_HOUR and stay idle 1000 cycles -> RUN, time_set=0, blink=0.
REQ-039 Bench: assert reset_ni=0 during auto-repeat -> all outputs return to reset values asynchronously, and no pulse follows release.
